// File: rtl/randist_sched.sv
// randist_sched: round-robin front end sharing one randist pipeline.
// Ports: req_* requesters, dp_* datapath, res_* consumer, cnt, err.
module randist_sched #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 16,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_push,
    input  logic [64*NREQ-1:0]   req_u1,
    input  logic [64*NREQ-1:0]   req_u2,
    output logic [NREQ-1:0]      req_ack,
    output logic                 dp_pushin,
    output logic [63:0]          dp_u1,
    output logic [63:0]          dp_u2,
    input  logic                 dp_pushout,
    input  logic [63:0]          dp_z,
    output logic                 res_push,
    output logic [63:0]          res_z,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_stop,
    output logic [CW-1:0]        cnt,
    output logic                 err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dp_pushin_q;
    logic [63:0]    dp_u1_q, dp_u2_q;
    logic           err_q;

    logic [IDW-1:0] tag_mem [DEPTH];
    logic [PW-1:0]  tag_wp_q, tag_rp_q;
    logic [63:0]    rz_mem  [DEPTH];
    logic [IDW-1:0] rid_mem [DEPTH];
    logic [PW-1:0]  res_wp_q, res_rp_q;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic           issue;
    logic           tag_empty, tag_pop;
    logic           res_empty, res_wr, res_rd;
    int             j;

    // First pushing requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!gnt_found && req_push[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(j);
            end
        end
    end

    // Credit check uses the registered count only, so a dequeue in
    // this cycle never frees a slot for an issue in the same cycle.
    assign issue   = rst && (cnt_q < CW'(DEPTH)) && gnt_found;
    assign req_ack = issue ? (NREQ'(1) << gnt_idx) : '0;

    assign tag_empty = (tag_wp_q == tag_rp_q);
    assign tag_pop   = dp_pushout && !tag_empty;
    assign res_empty = (res_wp_q == res_rp_q);
    assign res_wr    = tag_pop;
    assign res_rd    = !res_empty && !res_stop;

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            if (int'(gnt_idx) == NREQ - 1) ptr_d = '0;
            else                           ptr_d = gnt_idx + IDW'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({issue, res_rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            dp_pushin_q <= 1'b0;
            dp_u1_q     <= '0;
            dp_u2_q     <= '0;
            err_q       <= 1'b0;
            tag_wp_q    <= '0;
            tag_rp_q    <= '0;
            res_wp_q    <= '0;
            res_rp_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            dp_pushin_q <= issue;
            if (issue) begin
                dp_u1_q  <= req_u1[int'(gnt_idx)*64 +: 64];
                dp_u2_q  <= req_u2[int'(gnt_idx)*64 +: 64];
                tag_wp_q <= tag_wp_q + PW'(1);
            end
            if (tag_pop)                 tag_rp_q <= tag_rp_q + PW'(1);
            if (dp_pushout && tag_empty) err_q    <= 1'b1;
            if (res_wr)                  res_wp_q <= res_wp_q + PW'(1);
            if (res_rd)                  res_rp_q <= res_rp_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) tag_mem[tag_wp_q[AW-1:0]] <= gnt_idx;
        if (res_wr) begin
            rz_mem[res_wp_q[AW-1:0]]  <= dp_z;
            rid_mem[res_wp_q[AW-1:0]] <= tag_mem[tag_rp_q[AW-1:0]];
        end
    end

    // Head outputs read as zero when empty so reset shows clean values.
    assign res_push  = !res_empty;
    assign res_z     = res_empty ? '0 : rz_mem[res_rp_q[AW-1:0]];
    assign res_id    = res_empty ? '0 : rid_mem[res_rp_q[AW-1:0]];
    assign dp_pushin = dp_pushin_q;
    assign dp_u1     = dp_u1_q;
    assign dp_u2     = dp_u2_q;
    assign cnt       = cnt_q;
    assign err       = err_q;

endmodule
